player_ctrl_gen: RTL and testbench

// - Parametrised next-generation player controller: keyboard-driven motion, gravity, jump and aim/power state.
// - Consumes per-side collision flags from an external collider; issues a launch request to the projectile block.
// - Single clock domain: frame updates gated by a one-cycle frame_tick pulse, not by a frame clock.
// - Renders sprite hit-test and sprite ROM address for the VGA compositor.

---
 rtl/player_ctrl_gen.sv | 266 ++++++++++++++++++++++++++
 tb/tb_player_ctrl_gen.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_ctrl_gen.sv
// Frame-ticked player controller: motion, gravity, jump, aim/power, launch handshake and sprite render.
// Optional feature: define PLAYER_DOUBLE_JUMP_EN to allow one extra jump while airborne.
module player_ctrl_gen #(
  parameter int WIDTH     = 15,
  parameter int HEIGHT    = 25,
  parameter int CENTER_X  = 8,
  parameter int CENTER_Y  = 13,
  parameter int X_MIN     = 5,
  parameter int X_MAX     = 634,
  parameter int Y_MIN     = 5,
  parameter int Y_MAX     = 474,
  parameter int X_RESET   = 320,
  parameter int Y_RESET   = 200,
  parameter int VEL_W     = 6,
  parameter int V_MAX     = 7,
  parameter int GRAV_DIV  = 6,
  parameter int MOVE_DIV  = 6,
  parameter int JUMP_DIV  = 32,
  parameter int AIM_DIV   = 12,
  parameter int JUMP_IMP  = 4,
  parameter int ANGLE_MAX = 8,
  parameter int ANGLE_RST = 6,
  parameter int POWER_MAX = 7,
  parameter int POWER_RST = 2,
  parameter int SPR_OFS_R = 204,
  parameter int SPR_OFS_L = 579
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic [7:0]  keycode,
  input  logic        col_d,
  input  logic        col_u,
  input  logic        col_l,
  input  logic        col_r,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        launch_ack,
  output logic [9:0]  X_Pos,
  output logic [9:0]  Y_Pos,
  output logic [3:0]  angle,
  output logic [2:0]  power,
  output logic        launch_req,
  output logic        facing_left,
  output logic        airborne,
  output logic        drawPlayer,
  output logic [17:0] addrPlayer
);

  localparam int M1    = (GRAV_DIV > MOVE_DIV) ? GRAV_DIV : MOVE_DIV;
  localparam int M2    = (JUMP_DIV > AIM_DIV) ? JUMP_DIV : AIM_DIV;
  localparam int CNT_W = $clog2(((M1 > M2) ? M1 : M2) + 1);
  localparam int VW2   = VEL_W + 2;

  localparam logic [7:0] KEY_A = 8'h04, KEY_D = 8'h07, KEY_W = 8'h1A, KEY_Q = 8'h14;
  localparam logic [7:0] KEY_E = 8'h08, KEY_1 = 8'h1E, KEY_3 = 8'h20, KEY_S = 8'h16;

  localparam logic [CNT_W-1:0] GRAV_LAST = CNT_W'(GRAV_DIV - 1);
  localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_DIV - 1);
  localparam logic [CNT_W-1:0] JUMP_FULL = CNT_W'(JUMP_DIV);
  localparam logic [CNT_W-1:0] AIM_FULL  = CNT_W'(AIM_DIV);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic signed [VW2-1:0] VMAX_W = VW2'(V_MAX);
  localparam logic signed [VW2-1:0] VONE   = VW2'(1);
  localparam logic signed [VW2-1:0] VIMP   = VW2'(JUMP_IMP);
  localparam logic [VEL_W-1:0]      VMAX_N = VEL_W'(V_MAX);
  localparam logic [VEL_W-1:0]      VMIN_N = VEL_W'(-V_MAX);

  localparam logic signed [11:0] X_LO = 12'(X_MIN + CENTER_X);
  localparam logic signed [11:0] X_HI = 12'(X_MAX - WIDTH + CENTER_X);
  localparam logic signed [11:0] Y_LO = 12'(Y_MIN + CENTER_Y);
  localparam logic signed [11:0] Y_HI = 12'(Y_MAX - HEIGHT + CENTER_Y);
  localparam logic signed [11:0] PONE = 12'sd1;

  localparam logic [3:0] ANG_MAX = 4'(ANGLE_MAX);
  localparam logic [2:0] PWR_MAX = 3'(POWER_MAX);

  typedef enum logic {AIR = 1'b0, GROUND = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic [VEL_W-1:0] xv_q, xv_d, yv_q, yv_d;
  logic [CNT_W-1:0] grav_cnt_q, grav_cnt_d, move_cnt_q, move_cnt_d;
  logic [CNT_W-1:0] jump_cnt_q, jump_cnt_d, aim_cnt_q, aim_cnt_d;
  logic [3:0]       angle_q, angle_d;
  logic [2:0]       power_q, power_d;
  logic             req_q, req_d, face_q, face_d;
`ifdef PLAYER_DOUBLE_JUMP_EN
  logic             dj_q, dj_d;
`endif

  logic signed [VW2-1:0] xv, yv;
  logic signed [11:0]    xp, yp;
  logic                  ground, jumped, aim_step;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= AIR;
      x_q        <= 10'(X_RESET);
      y_q        <= 10'(Y_RESET);
      xv_q       <= '0;
      yv_q       <= '0;
      grav_cnt_q <= '0;
      move_cnt_q <= '0;
      jump_cnt_q <= '0;
      aim_cnt_q  <= '0;
      angle_q    <= 4'(ANGLE_RST);
      power_q    <= 3'(POWER_RST);
      req_q      <= 1'b0;
      face_q     <= 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
      dj_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      xv_q       <= xv_d;
      yv_q       <= yv_d;
      grav_cnt_q <= grav_cnt_d;
      move_cnt_q <= move_cnt_d;
      jump_cnt_q <= jump_cnt_d;
      aim_cnt_q  <= aim_cnt_d;
      angle_q    <= angle_d;
      power_q    <= power_d;
      req_q      <= req_d;
      face_q     <= face_d;
`ifdef PLAYER_DOUBLE_JUMP_EN
      dj_q       <= dj_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    xv_d       = xv_q;
    yv_d       = yv_q;
    grav_cnt_d = grav_cnt_q;
    move_cnt_d = move_cnt_q;
    jump_cnt_d = jump_cnt_q;
    aim_cnt_d  = aim_cnt_q;
    angle_d    = angle_q;
    power_d    = power_q;
    req_d      = req_q;
    face_d     = face_q;
`ifdef PLAYER_DOUBLE_JUMP_EN
    dj_d       = dj_q;
`endif
    xv         = {{2{xv_q[VEL_W-1]}}, xv_q};
    yv         = {{2{yv_q[VEL_W-1]}}, yv_q};
    xp         = {2'b00, x_q};
    yp         = {2'b00, y_q};
    ground     = (state_q == GROUND);
    jumped     = 1'b0;
    aim_step   = 1'b0;

    if (frame_tick) begin
      // Collision first; input and gravity then adjust the collided velocity.
      if (col_d && !yv[VW2-1]) begin
        yv = '0;
        yp = yp - PONE;
      end
      if (col_u && yv[VW2-1]) yv = '0;
      if (col_l && col_r)  xv = '0;
      else if (col_l)      xv = VONE;
      else if (col_r)      xv = -VONE;

      if (move_cnt_q == MOVE_LAST) begin
        move_cnt_d = '0;
        if (keycode == KEY_A)      xv = xv - VONE;
        else if (keycode == KEY_D) xv = xv + VONE;
        else if (xv > 0)           xv = xv - VONE;
        else if (xv < 0)           xv = xv + VONE;
      end else begin
        move_cnt_d = move_cnt_q + CNT_ONE;
      end

      if (jump_cnt_q != JUMP_FULL) jump_cnt_d = jump_cnt_q + CNT_ONE;
      if (keycode == KEY_W) begin
        if (ground && jump_cnt_q == JUMP_FULL) begin
          yv         = yv - VIMP;
          jump_cnt_d = '0;
          jumped     = 1'b1;
        end
`ifdef PLAYER_DOUBLE_JUMP_EN
        else if (!ground && dj_q) begin
          yv   = yv - VIMP;
          dj_d = 1'b0;
        end
`endif
      end

      if (ground) begin
        grav_cnt_d = '0;
      end else if (grav_cnt_q == GRAV_LAST) begin
        yv         = yv + VONE;
        grav_cnt_d = '0;
      end else begin
        grav_cnt_d = grav_cnt_q + CNT_ONE;
      end

      if (xv > VMAX_W)       xv_d = VMAX_N;
      else if (xv < -VMAX_W) xv_d = VMIN_N;
      else                   xv_d = xv[VEL_W-1:0];
      if (yv > VMAX_W)       yv_d = VMAX_N;
      else if (yv < -VMAX_W) yv_d = VMIN_N;
      else                   yv_d = yv[VEL_W-1:0];

      // Clamping to the playfield kills that axis's velocity instead of bouncing.
      xp = xp + {{(12-VEL_W){xv_d[VEL_W-1]}}, xv_d};
      yp = yp + {{(12-VEL_W){yv_d[VEL_W-1]}}, yv_d};
      if (xp < X_LO)      begin x_d = X_LO[9:0]; xv_d = '0; end
      else if (xp > X_HI) begin x_d = X_HI[9:0]; xv_d = '0; end
      else                x_d = xp[9:0];
      if (yp < Y_LO)      begin y_d = Y_LO[9:0]; yv_d = '0; end
      else if (yp > Y_HI) begin y_d = Y_HI[9:0]; yv_d = '0; end
      else                y_d = yp[9:0];

      if (xv_d != '0) face_d = xv_d[VEL_W-1];

      state_d = (col_d && !jumped) ? GROUND : AIR;
`ifdef PLAYER_DOUBLE_JUMP_EN
      if (state_d == GROUND) dj_d = 1'b1;
`endif

      if (aim_cnt_q == AIM_FULL) begin
        case (keycode)
          KEY_Q: begin if (angle_q != 4'd0)    angle_d = angle_q - 4'd1; aim_step = 1'b1; end
          KEY_E: begin if (angle_q < ANG_MAX)  angle_d = angle_q + 4'd1; aim_step = 1'b1; end
          KEY_1: begin if (power_q != 3'd0)    power_d = power_q - 3'd1; aim_step = 1'b1; end
          KEY_3: begin if (power_q < PWR_MAX)  power_d = power_q + 3'd1; aim_step = 1'b1; end
          KEY_S: if (!req_q && !launch_ack) begin req_d = 1'b1; aim_step = 1'b1; end
          default: ;
        endcase
      end
      if (aim_step)                aim_cnt_d = '0;
      else if (aim_cnt_q != AIM_FULL) aim_cnt_d = aim_cnt_q + CNT_ONE;
    end

    if (launch_ack) req_d = 1'b0;
  end

  // Unsigned wrap of DrawX-left makes one compare cover both box edges.
  logic [9:0] leftX, topY, dx, dy;
  assign leftX = x_q - 10'(CENTER_X);
  assign topY  = y_q - 10'(CENTER_Y);
  assign dx    = DrawX - leftX;
  assign dy    = DrawY - topY;

  assign drawPlayer = (dx < 10'(WIDTH)) && (dy < 10'(HEIGHT));
  assign addrPlayer = drawPlayer ?
                      ({8'd0, dy} * 18'(WIDTH) + {8'd0, dx} + (face_q ? 18'(SPR_OFS_L) : 18'(SPR_OFS_R))) :
                      18'd0;

  assign X_Pos       = x_q;
  assign Y_Pos       = y_q;
  assign angle       = angle_q;
  assign power       = power_q;
  assign launch_req  = req_q;
  assign facing_left = face_q;
  assign airborne    = (state_q == AIR);

endmodule

// File: tb/tb_player_ctrl_gen.sv
// Self-checking bench for player_ctrl_gen: directed scenarios plus randomized traffic against a tick-level model.
module tb_player_ctrl_gen;

  localparam int CX = 8, CY = 13, SW = 15, SH = 25;
  localparam int XLO = 13, XHI = 627, YLO = 18, YHI = 462;
  localparam int VMAX = 7, GRAV = 6, MOVE = 6, JUMPD = 32, AIMD = 12, JIMP = 4;
  localparam int ANGMAX = 8, PWRMAX = 7;
  localparam logic [7:0] KA = 8'h04, KD = 8'h07, KW = 8'h1A, KQ = 8'h14;
  localparam logic [7:0] KE = 8'h08, K1 = 8'h1E, K3 = 8'h20, KS = 8'h16;

  logic        clk = 1'b0;
  logic        reset, frame_tick, col_d, col_u, col_l, col_r, launch_ack;
  logic [7:0]  keycode;
  logic [9:0]  DrawX, DrawY;
  logic [9:0]  X_Pos, Y_Pos;
  logic [3:0]  angle;
  logic [2:0]  power;
  logic        launch_req, facing_left, airborne, drawPlayer;
  logic [17:0] addrPlayer;

  int checks = 0;
  int errors = 0;

  int mX, mY, mVX, mVY, mAngle, mPower, tickNo, lastJump, lastAim, gCount;
  bit mGround, mReq, mFace, mDj;

  player_ctrl_gen dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .keycode(keycode),
    .col_d(col_d), .col_u(col_u), .col_l(col_l), .col_r(col_r),
    .DrawX(DrawX), .DrawY(DrawY), .launch_ack(launch_ack),
    .X_Pos(X_Pos), .Y_Pos(Y_Pos), .angle(angle), .power(power),
    .launch_req(launch_req), .facing_left(facing_left), .airborne(airborne),
    .drawPlayer(drawPlayer), .addrPlayer(addrPlayer)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v);
    return (v > VMAX) ? VMAX : (v < -VMAX) ? -VMAX : v;
  endfunction

  function automatic logic [29:0] expState();
    return {10'(mX), 10'(mY), 4'(mAngle), 3'(mPower), mReq, mFace, !mGround};
  endfunction

  function automatic logic [18:0] expRender();
    int l, u;
    bit d;
    l = mX - CX;
    u = mY - CY;
    d = int'(DrawX) >= l && int'(DrawX) <= l + SW - 1 && int'(DrawY) >= u && int'(DrawY) <= u + SH - 1;
    return {d, d ? 18'((int'(DrawY) - u) * SW + (int'(DrawX) - l) + (mFace ? 579 : 204)) : 18'd0};
  endfunction

  task automatic modelReset();
    mX = 320; mY = 200; mVX = 0; mVY = 0; mAngle = 6; mPower = 2;
    tickNo = 0; lastJump = 0; lastAim = 0; gCount = 0;
    mGround = 0; mReq = 0; mFace = 0; mDj = 0;
  endtask

  // One frame of the player rules, applied in collision, input, gravity order on plain integers.
  task automatic modelStep(input bit tick, input logic [7:0] key, input bit cd, cu, cl, cr, ack);
    int vx, vy, nx, ny;
    bit jumped;
    if (tick) begin
      tickNo++;
      vx = mVX; vy = mVY; ny = mY; jumped = 0;
      if (cd && vy >= 0) begin vy = 0; ny--; end
      if (cu && vy < 0) vy = 0;
      if (cl && cr) vx = 0; else if (cl) vx = 1; else if (cr) vx = -1;
      if (tickNo % MOVE == 0) begin
        if (key == KA) vx--; else if (key == KD) vx++; else if (vx > 0) vx--; else if (vx < 0) vx++;
      end
      if (key == KW) begin
        if (mGround && tickNo - lastJump > JUMPD) begin vy -= JIMP; lastJump = tickNo; jumped = 1; end
`ifdef PLAYER_DOUBLE_JUMP_EN
        else if (!mGround && mDj) begin vy -= JIMP; mDj = 0; end
`endif
      end
      if (mGround) gCount = 0;
      else begin
        gCount++;
        if (gCount == GRAV) begin vy++; gCount = 0; end
      end
      vx = sat(vx); vy = sat(vy);
      nx = mX + vx; ny = ny + vy;
      if (nx < XLO) begin nx = XLO; vx = 0; end else if (nx > XHI) begin nx = XHI; vx = 0; end
      if (ny < YLO) begin ny = YLO; vy = 0; end else if (ny > YHI) begin ny = YHI; vy = 0; end
      if (vx != 0) mFace = (vx < 0);
      mGround = cd && !jumped;
`ifdef PLAYER_DOUBLE_JUMP_EN
      if (mGround) mDj = 1;
`endif
      if (tickNo - lastAim > AIMD) begin
        if (key == KQ)      begin mAngle = (mAngle > 0) ? mAngle - 1 : 0; lastAim = tickNo; end
        else if (key == KE) begin mAngle = (mAngle < ANGMAX) ? mAngle + 1 : ANGMAX; lastAim = tickNo; end
        else if (key == K1) begin mPower = (mPower > 0) ? mPower - 1 : 0; lastAim = tickNo; end
        else if (key == K3) begin mPower = (mPower < PWRMAX) ? mPower + 1 : PWRMAX; lastAim = tickNo; end
        else if (key == KS && !mReq && !ack) begin mReq = 1; lastAim = tickNo; end
      end
      mX = nx; mY = ny; mVX = vx; mVY = vy;
    end
    if (ack) mReq = 0;
  endtask

  task automatic applyStimulus(input bit tick, input logic [7:0] key, input bit cd, cu, cl, cr, ack);
    frame_tick = tick; keycode = key; col_d = cd; col_u = cu; col_l = cl; col_r = cr; launch_ack = ack;
    modelStep(tick, key, cd, cu, cl, cr, ack);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1; frame_tick = 0; keycode = 0; col_d = 0; col_u = 0; col_l = 0; col_r = 0; launch_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    modelReset();
  endtask

  task automatic test_reset();
    doReset();
    checks++;
    if ({X_Pos, Y_Pos, angle, power, launch_req, facing_left, airborne} !== {10'd320, 10'd200, 4'd6, 3'd2, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL reset_state got %h expected %h", {X_Pos, Y_Pos, angle, power, launch_req, facing_left, airborne},
               {10'd320, 10'd200, 4'd6, 3'd2, 1'b0, 1'b0, 1'b1});
    end
  endtask

  task automatic test_render();
    logic [9:0] xs [4] = '{10'd312, 10'd327, 10'd326, 10'd326};
    logic [9:0] ys [4] = '{10'd187, 10'd187, 10'd211, 10'd212};
    logic [18:0] req [4] = '{{1'b1, 18'd204}, {1'b0, 18'd0}, {1'b1, 18'd578}, {1'b0, 18'd0}};
    doReset();
    for (int i = 0; i < 4; i++) begin
      DrawX = xs[i]; DrawY = ys[i];
      #1;
      checks++;
      if ({drawPlayer, addrPlayer} !== req[i]) begin
        errors++;
        $display("[TB] FAIL render_%0d got draw=%b addr=%0d expected draw=%b addr=%0d", i, drawPlayer, addrPlayer, req[i][18], req[i][17:0]);
      end
    end
  endtask

  task automatic test_gravity();
    doReset();
    for (int t = 1; t <= 90; t++) begin
      applyStimulus(1, 8'h00, 0, 0, 0, 0, 0);
      checks++;
      if ({X_Pos, Y_Pos, angle, power, launch_req, facing_left, airborne} !== expState()) begin
        errors++;
        $display("[TB] FAIL gravity_tick%0d got %h expected %h", t, {X_Pos, Y_Pos, angle, power, launch_req, facing_left, airborne}, expState());
      end
    end
    checks++;
    if (Y_Pos !== 10'd462) begin errors++; $display("[TB] FAIL gravity_floor got %0d expected 462", Y_Pos); end
  endtask

  task automatic test_move();
    logic [9:0] prevX;
    doReset();
    prevX = X_Pos;
    for (int t = 1; t <= 45; t++) begin
      prevX = X_Pos;
      applyStimulus(1, KD, 1, 0, 0, 0, 0);
      checks++;
      if ({X_Pos, Y_Pos, facing_left, airborne} !== {10'(mX), 10'(mY), mFace, !mGround}) begin
        errors++;
        $display("[TB] FAIL move_hold_tick%0d got X=%0d Y=%0d expected X=%0d Y=%0d", t, X_Pos, Y_Pos, mX, mY);
      end
    end
    checks++;
    if (X_Pos - prevX !== 10'd7) begin errors++; $display("[TB] FAIL move_vmax got step %0d expected 7", X_Pos - prevX); end
    for (int t = 46; t <= 90; t++) applyStimulus(1, 8'h00, 1, 0, 0, 0, 0);
    checks++;
    if ({X_Pos, facing_left} !== {10'd614, 1'b0}) begin
      errors++;
      $display("[TB] FAIL move_friction got X=%0d face=%b expected X=614 face=0", X_Pos, facing_left);
    end
  endtask

  task automatic test_jump();
    doReset();
    for (int t = 1; t <= 33; t++) begin
      applyStimulus(1, KW, 1, 0, 0, 0, 0);
      checks++;
      if ({Y_Pos, airborne} !== {10'(mY), !mGround}) begin
        errors++;
        $display("[TB] FAIL jump_tick%0d got Y=%0d air=%b expected Y=%0d air=%b", t, Y_Pos, airborne, mY, !mGround);
      end
    end
    checks++;
    if ({Y_Pos, airborne} !== {10'd163, 1'b1}) begin
      errors++;
      $display("[TB] FAIL jump_accept got Y=%0d air=%b expected Y=163 air=1", Y_Pos, airborne);
    end
    applyStimulus(1, 8'h00, 0, 0, 0, 0, 0);
    applyStimulus(1, KW, 0, 0, 0, 0, 0);
    checks++;
`ifdef PLAYER_DOUBLE_JUMP_EN
    if (Y_Pos !== 10'd152) begin errors++; $display("[TB] FAIL jump_air got Y=%0d expected 152", Y_Pos); end
`else
    if (Y_Pos !== 10'd155) begin errors++; $display("[TB] FAIL jump_air got Y=%0d expected 155", Y_Pos); end
`endif
  endtask

  task automatic test_aim();
    doReset();
    for (int t = 1; t <= 200; t++) begin
      applyStimulus(1, KQ, 0, 0, 0, 0, 0);
      checks++;
      if (angle !== 4'(mAngle)) begin errors++; $display("[TB] FAIL aim_q_tick%0d got %0d expected %0d", t, angle, mAngle); end
      if (t == 12 || t == 13) begin
        checks++;
        if (angle !== ((t == 12) ? 4'd6 : 4'd5)) begin errors++; $display("[TB] FAIL aim_first_step tick%0d got %0d", t, angle); end
      end
    end
    checks++;
    if (angle !== 4'd0) begin errors++; $display("[TB] FAIL aim_angle_floor got %0d expected 0", angle); end
    for (int t = 201; t <= 280; t++) applyStimulus(1, K3, 0, 0, 0, 0, 0);
    checks++;
    if (power !== 3'd7) begin errors++; $display("[TB] FAIL aim_power_ceiling got %0d expected 7", power); end
  endtask

  task automatic test_launch();
    doReset();
    for (int t = 1; t <= 13; t++) begin
      applyStimulus(1, KS, 0, 0, 0, 0, 0);
      checks++;
      if (launch_req !== mReq || launch_req !== (t == 13)) begin
        errors++;
        $display("[TB] FAIL launch_set_tick%0d got %b expected %b", t, launch_req, t == 13);
      end
    end
    for (int c = 0; c < 5; c++) begin
      applyStimulus(0, KS, 0, 0, 0, 0, 0);
      checks++;
      if (launch_req !== 1'b1) begin errors++; $display("[TB] FAIL launch_hold_%0d got %b expected 1", c, launch_req); end
    end
    applyStimulus(0, KS, 0, 0, 0, 0, 1);
    checks++;
    if (launch_req !== 1'b0) begin errors++; $display("[TB] FAIL launch_ack got %b expected 0", launch_req); end
    for (int t = 14; t <= 26; t++) begin
      applyStimulus(1, KS, 0, 0, 0, 0, 0);
      checks++;
      if (launch_req !== (t == 26)) begin errors++; $display("[TB] FAIL launch_rearm_tick%0d got %b expected %b", t, launch_req, t == 26); end
    end
    applyStimulus(0, 8'h00, 0, 0, 0, 0, 1);
    for (int t = 27; t <= 38; t++) applyStimulus(1, 8'h00, 0, 0, 0, 0, 0);
    applyStimulus(1, KS, 0, 0, 0, 0, 1);
    checks++;
    if (launch_req !== 1'b0) begin errors++; $display("[TB] FAIL launch_collide got %b expected 0", launch_req); end
    applyStimulus(1, KS, 0, 0, 0, 0, 0);
    checks++;
    if (launch_req !== 1'b1) begin errors++; $display("[TB] FAIL launch_after_collide got %b expected 1", launch_req); end
  endtask

  task automatic test_random();
    logic [7:0] keys [10] = '{8'h00, KA, KD, KW, KQ, KE, K1, K3, KS, 8'h55};
    doReset();
    for (int c = 0; c < 1500; c++) begin
      DrawX = 10'(mX - 10 + int'($urandom_range(0, 34)));
      DrawY = 10'(mY - 15 + int'($urandom_range(0, 44)));
      applyStimulus($urandom_range(0, 1) == 1, keys[$urandom_range(0, 9)], $urandom_range(0, 2) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 5) == 0);
      checks++;
      if ({X_Pos, Y_Pos, angle, power, launch_req, facing_left, airborne, drawPlayer, addrPlayer} !== {expState(), expRender()}) begin
        errors++;
        $display("[TB] FAIL random_cycle%0d got %h expected %h", c,
                 {X_Pos, Y_Pos, angle, power, launch_req, facing_left, airborne, drawPlayer, addrPlayer}, {expState(), expRender()});
      end
    end
  endtask

  initial begin
    DrawX = 0; DrawY = 0;
    test_reset();
    test_render();
    test_gravity();
    test_move();
    test_jump();
    test_aim();
    test_launch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
